tron_round_ctrl: RTL and testbench



---
 rtl/tron_pkg.sv | 28 ++
 rtl/frame_tick.sv | 31 +++
 rtl/tron_round_ctrl.sv | 169 ++++++++++++++++
 tb/tb_tron_round_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// Shared types and constants for the light-cycle game: phase encoding seen by
// arena, key codes, and the point-result encoding.
package tron_pkg;

  typedef enum logic [2:0] {
    ST_TITLE     = 3'd0,
    ST_PLAY      = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_BLUE = 2'd1,
    WIN_RED  = 2'd2,
    WIN_DRAW = 2'd3
  } winner_t;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_ESC   = 8'h29;

  // Score increment that sticks at the winning score instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Brings the vsync-derived frame level into the Clk domain and emits a single
// registered pulse per rising edge, three Clk cycles after frame_clk rises.
module frame_tick (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync2_d;
  logic r_tick;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_sync1   <= frame_clk;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
      r_tick    <= r_sync2 & ~r_sync2_d;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/tron_round_ctrl.sv
// Round/score controller: sequences title, countdown, play, point and
// game-over phases for arena and keeps both players' scores.
module tron_round_ctrl
  import tron_pkg::*;
#(
  parameter int COUNT_FRAMES = 180,
  parameter int POINT_FRAMES = 120,
  parameter int WIN_SCORE    = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       Blue_crash,
  input  logic       Red_crash,
  output logic [2:0] Game_State,
  output logic       Reset_Score,
  output logic [3:0] Blue_Score,
  output logic [3:0] Red_Score,
  output logic [1:0] Countdown,
  output logic [1:0] Winner
);

  localparam logic [7:0] CNT_LAST = 8'(COUNT_FRAMES - 1);
  localparam logic [7:0] PNT_LAST = 8'(POINT_FRAMES - 1);
  // Smallest frame_cnt values where 3*frame_cnt/COUNT_FRAMES reaches 1 and 2.
  localparam logic [7:0] CD_T1    = 8'((COUNT_FRAMES + 2) / 3);
  localparam logic [7:0] CD_T2    = 8'((2 * COUNT_FRAMES + 2) / 3);
  localparam logic [3:0] WIN_LIM  = 4'(WIN_SCORE);

  logic        w_tick;
  logic        w_enter;
  logic        w_esc;

  game_state_t r_state,       w_state_next;
  logic [7:0]  r_frame_cnt,   w_frame_cnt_next;
  logic [3:0]  r_blue,        w_blue_next;
  logic [3:0]  r_red,         w_red_next;
  winner_t     r_winner,      w_winner_next;
  logic [1:0]  r_countdown,   w_countdown_next;
  logic        r_reset_score, w_reset_score_next;

  frame_tick u_frame_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (w_tick)
  );

  assign w_enter = (keycode == KEY_ENTER);
  assign w_esc   = (keycode == KEY_ESC);

  always_comb begin
    w_state_next     = r_state;
    w_frame_cnt_next = r_frame_cnt;
    w_blue_next      = r_blue;
    w_red_next       = r_red;
    w_winner_next    = r_winner;

    // ESC outranks ticks and every other key in the same cycle.
    if (w_esc && (r_state != ST_TITLE)) begin
      w_state_next     = ST_TITLE;
      w_frame_cnt_next = 8'd0;
      w_blue_next      = 4'd0;
      w_red_next       = 4'd0;
      w_winner_next    = WIN_NONE;
    end else begin
      unique case (r_state)
        ST_TITLE, ST_GAME_OVER: begin
          if (w_enter) begin
            w_state_next     = ST_COUNTDOWN;
            w_frame_cnt_next = 8'd0;
            w_blue_next      = 4'd0;
            w_red_next       = 4'd0;
            w_winner_next    = WIN_NONE;
          end
        end
        ST_COUNTDOWN: begin
          if (w_tick) begin
            if (r_frame_cnt == CNT_LAST) begin
              w_state_next     = ST_PLAY;
              w_frame_cnt_next = 8'd0;
            end else begin
              w_frame_cnt_next = r_frame_cnt + 8'd1;
            end
          end
        end
        ST_PLAY: begin
          if (w_tick && (Blue_crash || Red_crash)) begin
            w_state_next     = ST_POINT;
            w_frame_cnt_next = 8'd0;
            if (Blue_crash && Red_crash) begin
              w_winner_next = WIN_DRAW;
            end else if (Blue_crash) begin
              w_red_next    = sat_inc(r_red, WIN_LIM);
              w_winner_next = WIN_RED;
            end else begin
              w_blue_next   = sat_inc(r_blue, WIN_LIM);
              w_winner_next = WIN_BLUE;
            end
          end
        end
        ST_POINT: begin
          if (w_tick) begin
            if (r_frame_cnt == PNT_LAST) begin
              w_frame_cnt_next = 8'd0;
              if ((r_blue >= WIN_LIM) || (r_red >= WIN_LIM)) begin
                w_state_next = ST_GAME_OVER;
              end else begin
                w_state_next = ST_COUNTDOWN;
              end
            end else begin
              w_frame_cnt_next = r_frame_cnt + 8'd1;
            end
          end
        end
        default: begin
          w_state_next     = ST_TITLE;
          w_frame_cnt_next = 8'd0;
        end
      endcase
    end
  end

  // Registered side outputs are derived from the next state so they change
  // on the same edge as Game_State.
  always_comb begin
    w_countdown_next = 2'd0;
    if (w_state_next == ST_COUNTDOWN) begin
      if (w_frame_cnt_next < CD_T1) begin
        w_countdown_next = 2'd3;
      end else if (w_frame_cnt_next < CD_T2) begin
        w_countdown_next = 2'd2;
      end else begin
        w_countdown_next = 2'd1;
      end
    end
    w_reset_score_next = (w_state_next != r_state) &&
                         ((w_state_next == ST_COUNTDOWN) || (w_state_next == ST_TITLE));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= ST_TITLE;
      r_frame_cnt   <= 8'd0;
      r_blue        <= 4'd0;
      r_red         <= 4'd0;
      r_winner      <= WIN_NONE;
      r_countdown   <= 2'd0;
      r_reset_score <= 1'b1;
    end else begin
      r_state       <= w_state_next;
      r_frame_cnt   <= w_frame_cnt_next;
      r_blue        <= w_blue_next;
      r_red         <= w_red_next;
      r_winner      <= w_winner_next;
      r_countdown   <= w_countdown_next;
      r_reset_score <= w_reset_score_next;
    end
  end

  assign Game_State  = r_state;
  assign Reset_Score = r_reset_score;
  assign Blue_Score  = r_blue;
  assign Red_Score   = r_red;
  assign Countdown   = r_countdown;
  assign Winner      = r_winner;

endmodule

// File: tb/tb_tron_round_ctrl.sv
// Scoreboard bench for tron_round_ctrl: a game-rule model queues every
// expected change of the output bundle; a monitor pops one per observed change.
module tb_tron_round_ctrl;

  localparam int CF = 6;
  localparam int PF = 2;
  localparam int WS = 2;

  localparam int M_TITLE     = 0;
  localparam int M_PLAY      = 1;
  localparam int M_COUNTDOWN = 2;
  localparam int M_POINT     = 3;
  localparam int M_GAME_OVER = 4;

  localparam logic [7:0] K_ENTER = 8'h28;
  localparam logic [7:0] K_ESC   = 8'h29;

  logic       Clk        = 1'b0;
  logic       Reset      = 1'b1;
  logic       frame_clk  = 1'b0;
  logic [7:0] keycode    = 8'h00;
  logic       Blue_crash = 1'b0;
  logic       Red_crash  = 1'b0;
  logic [2:0] Game_State;
  logic       Reset_Score;
  logic [3:0] Blue_Score;
  logic [3:0] Red_Score;
  logic [1:0] Countdown;
  logic [1:0] Winner;

  tron_round_ctrl #(
    .COUNT_FRAMES (CF),
    .POINT_FRAMES (PF),
    .WIN_SCORE    (WS)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .Blue_crash  (Blue_crash),
    .Red_crash   (Red_crash),
    .Game_State  (Game_State),
    .Reset_Score (Reset_Score),
    .Blue_Score  (Blue_Score),
    .Red_Score   (Red_Score),
    .Countdown   (Countdown),
    .Winner      (Winner)
  );

  always #5 Clk = ~Clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_pushed = 16'hFFFF;

  // Game model in rule terms: phase, scores, last result, ticks seen in phase.
  int   m_state = M_TITLE;
  int   m_blue  = 0;
  int   m_red   = 0;
  int   m_win   = 0;
  int   m_cnt   = 0;
  logic m_rs    = 1'b1;

  function automatic logic [15:0] m_snap();
    int cd;
    cd = (m_state == M_COUNTDOWN) ? 3 - (m_cnt * 3) / CF : 0;
    return {3'(m_state), m_rs, 4'(m_blue), 4'(m_red), 2'(cd), 2'(m_win)};
  endfunction

  task automatic push();
    logic [15:0] s;
    s = m_snap();
    if (s != last_pushed) begin
      exp_q.push_back(s);
      last_pushed = s;
    end
  endtask

  task automatic m_pulse();
    m_rs = 1'b1;
    push();
    m_rs = 1'b0;
    push();
  endtask

  task automatic m_start(input bit clear);
    m_state = M_COUNTDOWN;
    m_cnt   = 0;
    if (clear) begin
      m_blue = 0;
      m_red  = 0;
      m_win  = 0;
    end
    m_pulse();
  endtask

  task automatic m_title();
    m_state = M_TITLE;
    m_cnt   = 0;
    m_blue  = 0;
    m_red   = 0;
    m_win   = 0;
    m_pulse();
  endtask

  task automatic model_key(input logic [7:0] k);
    if (k == K_ESC && m_state != M_TITLE) m_title();
    else if (k == K_ENTER && (m_state == M_TITLE || m_state == M_GAME_OVER)) m_start(1'b1);
  endtask

  task automatic model_tick(input logic b, input logic r, input logic [7:0] k);
    if (k == K_ESC && m_state != M_TITLE) begin
      m_title();
    end else begin
      case (m_state)
        M_TITLE, M_GAME_OVER: if (k == K_ENTER) m_start(1'b1);
        M_COUNTDOWN: begin
          m_cnt++;
          if (m_cnt == CF) begin
            m_state = M_PLAY;
            m_cnt   = 0;
          end
          push();
        end
        M_PLAY: begin
          if (b || r) begin
            if (b && r) begin
              m_win = 3;
            end else if (b) begin
              m_red = (m_red + 1 > WS) ? WS : m_red + 1;
              m_win = 2;
            end else begin
              m_blue = (m_blue + 1 > WS) ? WS : m_blue + 1;
              m_win  = 1;
            end
            m_state = M_POINT;
            m_cnt   = 0;
            push();
          end
        end
        M_POINT: begin
          m_cnt++;
          if (m_cnt == PF) begin
            if (m_blue >= WS || m_red >= WS) begin
              m_state = M_GAME_OVER;
              m_cnt   = 0;
              push();
            end else begin
              m_start(1'b0);
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One frame: flags held across the whole strobe, key present on the tick cycle.
  task automatic frame(input logic b, input logic r, input logic [7:0] k);
    model_tick(b, r, k);
    Blue_crash = b;
    Red_crash  = r;
    frame_clk  = 1'b1;
    repeat (3) @(posedge Clk);
    #1 keycode = k;
    @(posedge Clk);
    #1 keycode = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    frame_clk  = 1'b0;
    Blue_crash = 1'b0;
    Red_crash  = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    model_key(k);
    keycode = k;
    @(posedge Clk);
    #1 keycode = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic quiet_frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: every change of the output bundle must match the next queued snapshot.
  initial begin
    logic [15:0] prev;
    logic [15:0] cur;
    logic [15:0] exp;
    int          n;
    prev = 16'hFFFF;
    n    = 0;
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      cur = {Game_State, Reset_Score, Blue_Score, Red_Score, Countdown, Winner};
      if (cur != prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change #%0d: got %h, expected no change", n, cur);
        end else begin
          exp = exp_q.pop_front();
          if (cur != exp) begin
            errors++;
            $display("FAIL snapshot #%0d: got %h, expected %h", n, cur, exp);
          end else begin
            $display("txn %0d: state=%0d rst_score=%0d blue=%0d red=%0d countdown=%0d winner=%0d",
                     n, Game_State, Reset_Score, Blue_Score, Red_Score, Countdown, Winner);
          end
        end
        prev = cur;
        n++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          sel;
    int          c;
    logic [7:0]  k;
    m_title();
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_state", int'(Game_State), M_TITLE);
    chk("reset_rst_score", int'(Reset_Score), 1);
    chk("reset_blue", int'(Blue_Score), 0);
    chk("reset_red", int'(Red_Score), 0);
    chk("reset_countdown", int'(Countdown), 0);
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_score_after_release", int'(Reset_Score), 0);

    press(K_ENTER);
    for (int i = 0; i < CF; i++) frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'h00);
    chk("play_after_countdown", int'(Game_State), M_PLAY);

    frame(1'b1, 1'b0, 8'h00);
    chk("blue_crash_red_score", int'(Red_Score), 1);
    chk("blue_crash_winner", int'(Winner), 2);
    quiet_frames(PF);
    chk("point_to_countdown", int'(Game_State), M_COUNTDOWN);
    quiet_frames(CF);

    frame(1'b1, 1'b1, 8'h00);
    chk("draw_winner", int'(Winner), 3);
    chk("draw_red_unchanged", int'(Red_Score), 1);
    quiet_frames(PF + CF);

    frame(1'b0, 1'b0, K_ENTER);
    chk("enter_ignored_in_play", int'(Game_State), M_PLAY);
    frame(1'b1, 1'b0, 8'h00);
    quiet_frames(PF);
    chk("game_over", int'(Game_State), M_GAME_OVER);
    frame(1'b1, 1'b1, 8'h00);
    frame(1'b0, 1'b1, 8'h00);
    chk("game_over_red_held", int'(Red_Score), 2);
    press(K_ENTER);
    chk("restart_red_cleared", int'(Red_Score), 0);

    quiet_frames(CF);
    frame(1'b1, 1'b0, K_ESC);
    chk("esc_beats_crash_state", int'(Game_State), M_TITLE);
    chk("esc_beats_crash_red", int'(Red_Score), 0);

    press(K_ENTER);
    quiet_frames(3);
    m_title();
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("reset_mid_countdown", int'(Game_State), M_TITLE);
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;

    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 15));
      if (sel == 0) begin
        press(K_ESC);
      end else if (sel <= 3) begin
        press(K_ENTER);
      end else begin
        c = int'($urandom_range(0, 15));
        k = 8'h00;
        if (c == 0) k = K_ESC;
        else if (c <= 2) k = K_ENTER;
        else if (c == 3) k = 8'($urandom_range(1, 255));
        c = int'($urandom_range(0, 7));
        frame(c == 0 || c == 2, c == 1 || c == 2, k);
      end
    end

    repeat (10) @(posedge Clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
